// File: rtl/q6_11_to_e4m4_pipe.sv
// Three-stage converter from signed Q6.11 fixed point to E4M4 float (bias 8, exp 0 = zero).
// Stage 1 takes the magnitude, stage 2 normalises, stage 3 rounds and packs.
module q6_11_to_e4m4_pipe #(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  out_fp,
  output logic        out_flush,
  output logic        out_inexact
);

  // Handshake: a transfer happens on a side when valid && ready in the same cycle.
  // The whole pipe advances unless the output holds an untaken sample; then every
  // stage (data and valid) holds, and in_ready is low.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1 registers
  logic        s1_valid_q, s1_sign_q;
  logic [17:0] s1_mag_q, s1_mag_d;

  assign s1_mag_d = in_q[17] ? 18'(-in_q) : in_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_sign_q  <= in_q[17];
      s1_mag_q   <= s1_mag_d;
    end
  end

  // Stage 2: leading-one search; the shift puts the hidden one at bit 17 (dropped)
  logic [4:0]  lead_p;
  logic [16:0] norm;
  logic [3:0]  s2_exp_d;

  always_comb begin
    lead_p = 5'd0;
    for (int i = 0; i < 18; i++) begin
      if (s1_mag_q[i]) lead_p = 5'(i);
    end
    norm     = 17'(s1_mag_q << (5'd17 - lead_p));
    s2_exp_d = 4'(lead_p - 5'd3);
  end

  logic       s2_valid_q, s2_sign_q, s2_rnd_q, s2_stk_q, s2_small_q, s2_zero_q;
  logic [3:0] s2_exp_q, s2_mant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_mant_q  <= '0;
      s2_rnd_q   <= 1'b0;
      s2_stk_q   <= 1'b0;
      s2_small_q <= 1'b0;
      s2_zero_q  <= 1'b0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_exp_q   <= s2_exp_d;
      s2_mant_q  <= norm[16:13];
      s2_rnd_q   <= norm[12];
      s2_stk_q   <= |norm[11:0];
      s2_small_q <= (s1_mag_q < 18'd16);
      s2_zero_q  <= (s1_mag_q == 18'd0);
    end
  end

  // Stage 3: round, pack, flush small magnitudes to an unsigned zero
  logic [4:0] mant_sum;
  logic [8:0] fp_d;
  logic       flush_d, inexact_d;
  logic [3:0] exp_r, mant_r;

  always_comb begin
    mant_sum  = {1'b0, s2_mant_q} + 5'd1;
    exp_r     = s2_exp_q;
    mant_r    = s2_mant_q;
    if (ROUND_EN && s2_rnd_q) begin
      // A carry out of the mantissa bumps the exponent; the top input lands at exp 14
      if (mant_sum[4]) begin
        mant_r = 4'd0;
        exp_r  = s2_exp_q + 4'd1;
      end else begin
        mant_r = mant_sum[3:0];
      end
    end
    fp_d      = {s2_sign_q, exp_r, mant_r};
    flush_d   = 1'b0;
    inexact_d = s2_rnd_q | s2_stk_q;
    if (s2_small_q) begin
      fp_d      = 9'h000;
      flush_d   = !s2_zero_q;
      inexact_d = !s2_zero_q;
    end
  end

  logic       out_valid_q, out_flush_q, out_inexact_q;
  logic [8:0] out_fp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_fp_q      <= 9'h000;
      out_flush_q   <= 1'b0;
      out_inexact_q <= 1'b0;
    end else if (advance) begin
      out_valid_q   <= s2_valid_q;
      out_fp_q      <= fp_d;
      out_flush_q   <= flush_d;
      out_inexact_q <= inexact_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_fp      = out_fp_q;
  assign out_flush   = out_flush_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_q6_11_to_e4m4_pipe.sv
// Directed bench for q6_11_to_e4m4_pipe: single vectors, backpressure,
// mid-stream reset and an E4M4 round trip under random out_ready.
module tb_q6_11_to_e4m4_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] in_q = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [8:0]  out_fp;
  logic        out_flush, out_inexact;

  logic        t_in_ready, t_out_valid, t_out_flush, t_out_inexact;
  logic [8:0]  t_out_fp;

  int tests_run = 0;
  int tests_failed = 0;
  int rx_cnt = 0;
  bit mon_en = 1'b0;
  bit rand_rdy = 1'b0;
  logic [9:0] exp_q[$];

  q6_11_to_e4m4_pipe #(.ROUND_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp),
    .out_flush(out_flush), .out_inexact(out_inexact)
  );

  q6_11_to_e4m4_pipe #(.ROUND_EN(1'b0)) dut_trunc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready), .in_q(in_q),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_fp(t_out_fp),
    .out_flush(t_out_flush), .out_inexact(t_out_inexact)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare every output transfer against the expected queue
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() != 0) check("stream", {out_inexact, out_fp}, exp_q.pop_front());
      rx_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic push(input logic [17:0] q);
    int n;
    logic acc;
    in_valid = 1'b1;
    in_q = q;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    check("push_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_single(input string tag, input logic [17:0] q, input logic [8:0] efp,
                             input logic ef, input logic ei);
    int lat;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_q = q;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 3);
    check({tag, "_fp"}, out_fp, efp);
    check({tag, "_flush"}, out_flush, ef);
    check({tag, "_inexact"}, out_inexact, ei);
  endtask

  logic [17:0] bp_q[8];
  logic [9:0]  bp_e[8];
  logic [8:0]  held;
  logic [17:0] rq;
  int          v, n;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_fp", out_fp, 0);
    check("rst_out_flush", out_flush, 0);
    check("rst_out_inexact", out_inexact, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // Single vectors
    send_single("one", 18'h00800, 9'h080, 1'b0, 1'b0);
    send_single("tie_away", 18'd2112, 9'h081, 1'b0, 1'b1);
    send_single("below_tie", 18'd2111, 9'h080, 1'b0, 1'b1);
    send_single("neg_max", 18'h20000, 9'h1E0, 1'b0, 1'b0);
    send_single("pos_max", 18'h1FFFF, 9'h0E0, 1'b0, 1'b1);
    check("trunc_fp", t_out_fp, 9'h0DF);
    check("trunc_inexact", t_out_inexact, 1);
    send_single("min_norm", 18'h00010, 9'h010, 1'b0, 1'b0);
    send_single("neg_min_norm", 18'h3FFF0, 9'h110, 1'b0, 1'b0);
    send_single("flush_pos", 18'd15, 9'h000, 1'b1, 1'b1);
    send_single("flush_neg", 18'h3FFF1, 9'h000, 1'b1, 1'b1);
    send_single("zero", 18'd0, 9'h000, 1'b0, 1'b0);

    // Backpressure: 8 back-to-back samples, 5-cycle stall on the first output
    bp_q[0] = 18'h00800; bp_e[0] = 10'h080;
    bp_q[1] = 18'd2112;  bp_e[1] = 10'h281;
    bp_q[2] = 18'd2111;  bp_e[2] = 10'h280;
    bp_q[3] = 18'h20000; bp_e[3] = 10'h1E0;
    bp_q[4] = 18'h1FFFF; bp_e[4] = 10'h2E0;
    bp_q[5] = 18'h00010; bp_e[5] = 10'h010;
    bp_q[6] = 18'h3FFF0; bp_e[6] = 10'h110;
    bp_q[7] = 18'd15;    bp_e[7] = 10'h200;
    @(posedge clk);
    #1;
    rx_cnt = 0;
    mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          exp_q.push_back(bp_e[i]);
          push(bp_q[i]);
        end
      end
      begin
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!out_valid && n < 20);
        check("bp_first_valid", out_valid, 1);
        out_ready = 1'b0;
        held = out_fp;
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready_low", in_ready, 0);
          check("bp_valid_held", out_valid, 1);
          check("bp_fp_stable", out_fp, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("bp_drain", exp_q.size(), 0);
    check("bp_count", rx_cnt, 8);
    mon_en = 1'b0;

    // Reset with samples in flight
    push(18'h00800);
    push(18'd2112);
    push(18'h20000);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_fp", out_fp, 0);
    check("mid_rst_inexact", out_inexact, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    repeat (6) begin
      @(negedge clk);
      check("no_stale", out_valid, 0);
    end
    send_single("after_rst", 18'd2111, 9'h080, 1'b0, 1'b1);

    // Round trip of every code with exp 1..13 (both signs) plus 9'h1E0
    @(posedge clk);
    #1;
    rx_cnt = 0;
    mon_en = 1'b1;
    rand_rdy = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int e = 1; e <= 13; e++) begin
        for (int m = 0; m < 16; m++) begin
          v = (16 + m) << (e - 1);
          rq = (s != 0) ? 18'(-v) : 18'(v);
          exp_q.push_back({1'b0, 1'(s), 4'(e), 4'(m)});
          push(rq);
        end
      end
    end
    exp_q.push_back(10'h1E0);
    push(18'h20000);
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("rt_drain", exp_q.size(), 0);
    check("rt_count", rx_cnt, 417);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
